// File: rtl/iob_gpio_irq.sv
// GPIO peripheral on the IOb native slave bus: output/enable registers, synchronised and
// debounced inputs, per-bit edge detection into a sticky W1C status with one level irq.
module iob_gpio_irq #(
  parameter int              GPIO_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 4,
  parameter int              DEB_W       = 16,
  parameter logic [DEB_W-1:0] DEB_RST    = 16'd1000,
  parameter int              SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [GPIO_W-1:0]   gpio_input,
  output logic [GPIO_W-1:0]   gpio_output,
  output logic [GPIO_W-1:0]   gpio_output_enable,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SET     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CLR     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_OE      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IRQ_EN  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_RISE_EN = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_FALL_EN = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_DEB     = ADDR_W'(9);

  function automatic logic [DATA_W-1:0] byte_mask(input logic [DATA_W/8-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < DATA_W/8; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] zext_gpio(input logic [GPIO_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[GPIO_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext_deb(input logic [DEB_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[DEB_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [GPIO_W-1:0] merge(input logic [GPIO_W-1:0] old,
                                              input logic [GPIO_W-1:0] val,
                                              input logic [GPIO_W-1:0] m);
    return (old & ~m) | (val & m);
  endfunction

  logic                accept;
  logic                we;
  logic [DATA_W-1:0]   wmask;
  logic [GPIO_W-1:0]   wm_g;
  logic [GPIO_W-1:0]   wd_g;
  logic [DATA_W-1:0]   rd_mux;

  logic [GPIO_W-1:0]   out_reg;
  logic [GPIO_W-1:0]   oe_reg;
  logic [GPIO_W-1:0]   irq_en;
  logic [GPIO_W-1:0]   rise_en;
  logic [GPIO_W-1:0]   fall_en;
  logic [GPIO_W-1:0]   irq_status;
  logic [DEB_W-1:0]    deb_limit;

  logic [GPIO_W-1:0]   sync_p [SYNC_STAGES];
  logic [GPIO_W-1:0]   sync;
  logic [GPIO_W-1:0]   stable;
  logic [DEB_W-1:0]    cnt [GPIO_W];
  logic [GPIO_W-1:0]   hit;
  logic [GPIO_W-1:0]   rise;
  logic [GPIO_W-1:0]   fall;
  logic [GPIO_W-1:0]   w1c;

  assign accept = valid && !ready;
  assign we     = |wstrb;
  assign wmask  = byte_mask(wstrb);
  assign wm_g   = wmask[GPIO_W-1:0];
  assign wd_g   = wdata[GPIO_W-1:0];

  // Input synchroniser stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= gpio_input;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  // A bit commits once its disagreement has lasted DEB_LIMIT cycles (limit 0 behaves as 1)
  always_comb begin
    hit = '0;
    for (int i = 0; i < GPIO_W; i++) begin
      hit[i] = (sync[i] != stable[i]) &&
               (({1'b0, cnt[i]} + {{DEB_W{1'b0}}, 1'b1}) >= {1'b0, deb_limit});
    end
  end

  assign rise = hit & sync & rise_en;
  assign fall = hit & ~sync & fall_en;
  assign w1c  = (accept && we && address == A_STATUS) ? (wd_g & wm_g) : '0;

  // Debounce stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < GPIO_W; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ hit;
      for (int i = 0; i < GPIO_W; i++)
        cnt[i] <= ((sync[i] != stable[i]) && !hit[i]) ? cnt[i] + DEB_W'(1) : '0;
    end
  end

  // Set has priority over a W1C landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_status <= '0;
    else     irq_status <= (irq_status & ~w1c) | rise | fall;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_OUT:     rd_mux = zext_gpio(out_reg);
      A_OE:      rd_mux = zext_gpio(oe_reg);
      A_IN:      rd_mux = zext_gpio(stable);
      A_IRQ_EN:  rd_mux = zext_gpio(irq_en);
      A_RISE_EN: rd_mux = zext_gpio(rise_en);
      A_FALL_EN: rd_mux = zext_gpio(fall_en);
      A_STATUS:  rd_mux = zext_gpio(irq_status);
      A_DEB:     rd_mux = zext_deb(deb_limit);
      default:   rd_mux = '0;
    endcase
  end

  // Bus access stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b0;
      rdata     <= '0;
      out_reg   <= '0;
      oe_reg    <= '0;
      irq_en    <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      deb_limit <= DEB_RST;
    end else begin
      ready <= accept;
      if (accept) rdata <= rd_mux;
      if (accept && we) begin
        case (address)
          A_OUT:     out_reg   <= merge(out_reg, wd_g, wm_g);
          A_SET:     out_reg   <= out_reg | (wd_g & wm_g);
          A_CLR:     out_reg   <= out_reg & ~(wd_g & wm_g);
          A_OE:      oe_reg    <= merge(oe_reg, wd_g, wm_g);
          A_IRQ_EN:  irq_en    <= merge(irq_en, wd_g, wm_g);
          A_RISE_EN: rise_en   <= merge(rise_en, wd_g, wm_g);
          A_FALL_EN: fall_en   <= merge(fall_en, wd_g, wm_g);
          A_DEB:     deb_limit <= (deb_limit & ~wmask[DEB_W-1:0]) |
                                  (wdata[DEB_W-1:0] & wmask[DEB_W-1:0]);
          default:   ;
        endcase
      end
    end
  end

  assign gpio_output        = out_reg;
  assign gpio_output_enable = oe_reg;
  assign irq                = |(irq_status & irq_en);

endmodule

// File: tb/tb_iob_gpio_irq.sv
// Bench for iob_gpio_irq: register vector table, debounce/irq/reset corner sequences,
// and randomized register traffic checked against a register-level model.
module tb_iob_gpio_irq;
  localparam int GPIO_W = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEB_W = 16;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] gpio_input = '0;
  logic [31:0] gpio_output;
  logic [31:0] gpio_output_enable;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_gpio_irq #(
    .GPIO_W(GPIO_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEB_W(DEB_W),
    .DEB_RST(16'd1000), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .gpio_input(gpio_input),
    .gpio_output(gpio_output), .gpio_output_enable(gpio_output_enable), .irq(irq)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready) begin seen = 1'b1; break; end
    end
    rd = rdata;
    valid = 1'b0; wstrb = '0;
    chk("ready_seen", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'b0, ready}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    access(a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    access(a, 32'h0, 4'h0, r);
    chk(name, r, exp);
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  initial begin
    logic [31:0] r, d, m, exp;
    logic [3:0]  a, s;
    logic        seen_irq;
    logic [31:0] m_out, m_oe, m_ien, m_ren, m_fen, m_st, m_deb, m_in;

    tv[0]  = '{4'd0,  32'h0, 4'h0, 32'h0};
    tv[1]  = '{4'd1,  32'h0, 4'h0, 32'h0};
    tv[2]  = '{4'd2,  32'h0, 4'h0, 32'h0};
    tv[3]  = '{4'd3,  32'h0, 4'h0, 32'h0};
    tv[4]  = '{4'd4,  32'h0, 4'h0, 32'h0};
    tv[5]  = '{4'd5,  32'h0, 4'h0, 32'h0};
    tv[6]  = '{4'd6,  32'h0, 4'h0, 32'h0};
    tv[7]  = '{4'd7,  32'h0, 4'h0, 32'h0};
    tv[8]  = '{4'd8,  32'h0, 4'h0, 32'h0};
    tv[9]  = '{4'd9,  32'h0, 4'h0, 32'd1000};
    tv[10] = '{4'd15, 32'h0, 4'h0, 32'h0};
    tv[11] = '{4'd0,  32'h0000_00F0, 4'hF, 32'h0};
    tv[12] = '{4'd1,  32'h0000_000F, 4'hF, 32'h0};
    tv[13] = '{4'd2,  32'h0000_0030, 4'hF, 32'h0};
    tv[14] = '{4'd1,  32'hFF00_0000, 4'h1, 32'h0};
    tv[15] = '{4'd0,  32'h0, 4'h0, 32'h0000_00CF};
    tv[16] = '{4'd1,  32'h0, 4'h0, 32'h0};
    tv[17] = '{4'd3,  32'h1234_5678, 4'h5, 32'h0};
    tv[18] = '{4'd3,  32'h0, 4'h0, 32'h0034_0078};
    tv[19] = '{4'd4,  32'hFFFF_FFFF, 4'hF, 32'h0};
    tv[20] = '{4'd4,  32'h0, 4'h0, 32'h0};
    tv[21] = '{4'd10, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tv[22] = '{4'd10, 32'h0, 4'h0, 32'h0};
    tv[23] = '{4'd2,  32'h0, 4'h0, 32'h0};

    // reset state
    #22;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_out", gpio_output, 32'h0);
    chk("rst_oe", gpio_output_enable, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      access(tv[i].addr, tv[i].wd, tv[i].strb, r);
      if (tv[i].strb == 4'h0) chk($sformatf("vec%0d_rdata", i), r, tv[i].exp);
    end
    chk("vec_gpio_output", gpio_output, 32'h0000_00CF);
    chk("vec_gpio_oe", gpio_output_enable, 32'h0034_0078);

    // debounce: glitch is filtered, held level commits after SYNC_STAGES+4 edges
    wr(4'd9, 32'd4);
    wr(4'd6, 32'h8);
    wr(4'd5, 32'h8);
    @(negedge clk); gpio_input[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_input[3] = 1'b0;
    seen_irq = 1'b0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; seen_irq |= irq; end
    chk("glitch_no_irq", {31'b0, seen_irq}, 32'd0);
    rd_chk("glitch_in", 4'd4, 32'h0);
    @(negedge clk); gpio_input[3] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 4; k++) begin
      @(posedge clk); #1;
      if (k == SYNC_STAGES + 3) chk("deb_irq_early", {31'b0, irq}, 32'd0);
      if (k == SYNC_STAGES + 4) chk("deb_irq_on_time", {31'b0, irq}, 32'd1);
    end
    repeat (6) @(posedge clk);
    rd_chk("deb_in", 4'd4, 32'h8);
    rd_chk("deb_status", 4'd8, 32'h8);
    wr(4'd8, 32'h8);
    chk("deb_w1c_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); gpio_input[3] = 1'b0;
    repeat (10) @(posedge clk);
    rd_chk("deb_fall_status", 4'd8, 32'h0);

    // rise irq, W1C, fall disabled, irq masking
    wr(4'd9, 32'd1);
    wr(4'd6, 32'h1);
    wr(4'd5, 32'h1);
    wr(4'd7, 32'h0);
    @(negedge clk); gpio_input[0] = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("rise_irq", {31'b0, irq}, 32'd1);
    rd_chk("rise_status", 4'd8, 32'h1);
    wr(4'd8, 32'h1);
    chk("w1c_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); gpio_input[0] = 1'b0;
    repeat (6) @(posedge clk);
    rd_chk("fall_dis_status", 4'd8, 32'h0);
    @(negedge clk); gpio_input[0] = 1'b1;
    repeat (6) @(posedge clk);
    wr(4'd5, 32'h0);
    chk("mask_irq", {31'b0, irq}, 32'd0);
    rd_chk("mask_status_kept", 4'd8, 32'h1);
    wr(4'd5, 32'h1);
    chk("unmask_irq", {31'b0, irq}, 32'd1);
    @(negedge clk); gpio_input[0] = 1'b0;
    repeat (6) @(posedge clk);
    rd_chk("pre_collide_status", 4'd8, 32'h1);

    // W1C and a new rising event on the same edge: set wins
    @(negedge clk); gpio_input[0] = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    @(negedge clk);
    valid = 1'b1; address = 4'd8; wdata = 32'h1; wstrb = 4'hF;
    @(posedge clk); #1;
    chk("collide_ready", {31'b0, ready}, 32'd1);
    valid = 1'b0; wstrb = '0;
    @(posedge clk); #1;
    chk("collide_ready_drop", {31'b0, ready}, 32'd0);
    rd_chk("collide_status", 4'd8, 32'h1);
    wr(4'd8, 32'h1);
    rd_chk("collide_cleared", 4'd8, 32'h0);

    // reset during an OUT write with the input held high
    @(negedge clk);
    valid = 1'b1; address = 4'd0; wdata = 32'h0000_00AB; wstrb = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'b0, ready}, 32'd0);
    chk("rst_mid_out", gpio_output, 32'h0);
    @(negedge clk); valid = 1'b0; wstrb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_irq = 1'b0;
    for (int k = 0; k < 1010; k++) begin @(posedge clk); #1; seen_irq |= irq; end
    chk("post_rst_no_irq", {31'b0, seen_irq}, 32'd0);
    rd_chk("post_rst_in", 4'd4, 32'h1);
    rd_chk("post_rst_status", 4'd8, 32'h0);
    rd_chk("post_rst_out", 4'd0, 32'h0);
    rd_chk("post_rst_deb", 4'd9, 32'd1000);

    // randomized register traffic against a register-level model
    m_out = 0; m_oe = 0; m_ien = 0; m_ren = 0; m_fen = 0; m_st = 0;
    m_deb = 32'd1000; m_in = 32'h1;
    for (int n = 0; n < 200; n++) begin
      a = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d = $urandom;
      access(a, d, s, r);
      m = strb_mask(s);
      if (s == 4'h0) begin
        case (a)
          4'd0: exp = m_out;
          4'd3: exp = m_oe;
          4'd4: exp = m_in;
          4'd5: exp = m_ien;
          4'd6: exp = m_ren;
          4'd7: exp = m_fen;
          4'd8: exp = m_st;
          4'd9: exp = m_deb;
          default: exp = 32'h0;
        endcase
        chk("rand_rdata", r, exp);
      end else begin
        case (a)
          4'd0: m_out = (m_out & ~m) | (d & m);
          4'd1: m_out = m_out | (d & m);
          4'd2: m_out = m_out & ~(d & m);
          4'd3: m_oe  = (m_oe & ~m) | (d & m);
          4'd5: m_ien = (m_ien & ~m) | (d & m);
          4'd6: m_ren = (m_ren & ~m) | (d & m);
          4'd7: m_fen = (m_fen & ~m) | (d & m);
          4'd8: m_st  = m_st & ~(d & m);
          4'd9: m_deb = ((m_deb & ~m) | (d & m)) & 32'h0000_FFFF;
          default: ;
        endcase
      end
      chk("rand_out", gpio_output, m_out);
      chk("rand_oe", gpio_output_enable, m_oe);
      chk("rand_irq", {31'b0, irq}, {31'b0, |(m_st & m_ien)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_gpio_irq.md
Name: iob_gpio_irq

Overview:
Parametrised GPIO peripheral on the IOb native CPU slave bus. Provides GPIO_W channels with per-bit output enable, atomic set/clear of outputs, and input synchronisation. Each input also has a programmable debounce filter and per-bit rising/falling edge detection feeding a sticky, write-1-to-clear interrupt status with a single level interrupt line. It sits beside the CPU as a memory-mapped peripheral, driving pads or an external tristate module.

Parameters:
GPIO_W, 32, number of channels, 1..DATA_W; register bits above GPIO_W read 0 and ignore writes
DATA_W, 32, CPU data width
ADDR_W, 4, word-address width of the register section
DEB_W, 16, debounce counter and DEB_LIMIT width
DEB_RST, 16'd1000, reset value of DEB_LIMIT
SYNC_STAGES, 2, input synchroniser depth, >=2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
valid  in  1  CPU request, held until ready
address  in  ADDR_W  word address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte write strobes; all zero means read
rdata  out  DATA_W  read data, valid while ready=1
ready  out  1  one-cycle completion pulse
gpio_input  in  GPIO_W  asynchronous pad inputs
gpio_output  out  GPIO_W  output register
gpio_output_enable  out  GPIO_W  per-bit output enable
irq  out  1  level interrupt

Behaviour:
- Register map (word address): 0 OUT RW; 1 OUT_SET W (OUT |= wdata); 2 OUT_CLR W (OUT &= ~wdata); 3 OE RW; 4 IN R (debounced value); 5 IRQ_EN RW; 6 RISE_EN RW; 7 FALL_EN RW; 8 IRQ_STATUS R/W1C; 9 DEB_LIMIT RW (DEB_W LSBs).
- Write-only registers and unmapped addresses read 0. Writes to read-only or unmapped addresses are ignored.
- All writes are masked per byte by wstrb. Bytes with a strobe of 0 leave SET/CLR/W1C bits untouched.
- Handshake: a request is accepted on a rising edge where valid=1 and ready=0. Write effects and rdata are registered on that edge. ready=1 for exactly the next cycle.
- A valid held high across ready starts the next access on the cycle after ready, giving one access per 2 cycles. The bus has no error response.
- Input path: gpio_input passes through SYNC_STAGES flops to give sync.
- Debounce: each bit has a counter cnt. If sync==stable, cnt<=0. Otherwise cnt increments, and when cnt+1 >= DEB_LIMIT, stable<=sync and cnt<=0.
- DEB_LIMIT 0 and 1 are equivalent: stable follows sync after 1 cycle. A pad change is therefore visible in IN after SYNC_STAGES+max(DEB_LIMIT,1) edges. A glitch shorter than DEB_LIMIT cycles never reaches stable.
- Writing DEB_LIMIT mid-count takes effect for the comparison on the next cycle; counters are not cleared.
- Edge events: rise[i] = stable 0->1 & RISE_EN[i]; fall[i] = stable 1->0 & FALL_EN[i]. An event sets IRQ_STATUS[i] on the same edge that stable updates.
- IRQ_STATUS is sticky. Writing 1 clears a bit. If an event and a W1C hit the same bit on the same edge, set wins.
- irq = OR over (IRQ_STATUS & IRQ_EN), decoded from flops only. It is glitch-free and asserts the cycle IRQ_STATUS becomes visible. Clearing IRQ_EN masks irq without clearing status.
- gpio_output=OUT and gpio_output_enable=OE, driven directly from the registers. They change the cycle after the accept edge.
- Reset values: OUT, OE, IRQ_EN, RISE_EN, FALL_EN, IRQ_STATUS = 0; DEB_LIMIT = DEB_RST; sync and stable = 0; cnt = 0; ready=0; rdata=0; irq=0.
- Reset asserted mid-access aborts it: no write effect and no ready pulse.
- After reset release, an input held high produces a stable 0->1 transition. This sets status only if RISE_EN was programmed first. RISE_EN resets to 0, so there is no spurious irq.

Test Plan:
- Reset, then read all registers -> OUT/OE/EN/STATUS=0, DEB_LIMIT=1000, IN=0, irq=0; ready high exactly 1 cycle per access.
- Write OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30; then write OUT_SET=0xFF00_0000 with wstrb=4'b0001 -> gpio_output=0x0000_00CF.
- DEB_LIMIT=4; pulse gpio_input[3] high for 3 cycles -> IN unchanged. Hold it high 10 cycles -> IN[3]=1 exactly SYNC_STAGES+4 edges after the change.
- RISE_EN=0x1, IRQ_EN=0x1, gpio_input[0] 0->1 -> IRQ_STATUS=0x1 and irq=1. W1C 0x1 -> irq=0. A falling edge with FALL_EN=0 leaves STATUS=0.
- Time a W1C of bit 0 onto the same edge as a new rising event on bit 0 -> IRQ_STATUS[0] stays 1.
- Assert rst during an OUT write with gpio_input high -> no ready, OUT=0. After release, IN reaches 1 after debounce and IRQ_STATUS stays 0.
